// File: rtl/ysyx_23060042_idu_stage.sv
// Instruction decode stage: decodes {pc, inst} on push and holds the decoded
// records in a small in-order buffer that drains to the execute stage.
module ysyx_23060042_idu_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_inst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_func3,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic            out_regen,
    output logic            out_pcjen,
    output logic            out_pcren,
    output logic            out_jalen,
    output logic            out_brken,
    output logic            out_memen,
    output logic            out_illegal
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_IMM     = 7'b0010011;
    localparam logic [6:0] OP_REG     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM  = 7'b1110011;
    localparam logic [6:0] OP_IMM_32  = 7'b0011011;
    localparam logic [6:0] OP_REG_32  = 7'b0111011;

    typedef enum logic [2:0] {
        IMM_R,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_sel_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [2:0]      func3;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic            regen;
        logic            pcjen;
        logic            pcren;
        logic            brken;
        logic            memen;
        logic            illegal;
    } rec_t;

    imm_sel_e        imm_sel;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] dec_imm;
    logic            dec_regen;
    logic            dec_pcjen;
    logic            dec_pcren;
    logic            dec_brken;
    logic            dec_memen;
    logic            dec_illegal;
    rec_t            dec_rec;

    rec_t             entries [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    rec_t             head;

    assign imm_i = XLEN'($signed(in_inst[31:20]));
    assign imm_s = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
    assign imm_b = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({in_inst[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));

    // Opcode class decode; anything unrecognised is flagged illegal with every enable low.
    always_comb begin
        imm_sel     = IMM_R;
        dec_regen   = 1'b0;
        dec_pcjen   = 1'b0;
        dec_pcren   = 1'b0;
        dec_brken   = 1'b0;
        dec_memen   = 1'b0;
        dec_illegal = 1'b0;
        case (in_inst[6:0])
            OP_LUI: begin
                dec_regen = 1'b1;
                imm_sel   = IMM_U;
            end
            OP_AUIPC: begin
                dec_regen = 1'b1;
                dec_pcren = 1'b1;
                imm_sel   = IMM_U;
            end
            OP_JAL: begin
                dec_regen = 1'b1;
                dec_pcjen = 1'b1;
                dec_pcren = 1'b1;
                imm_sel   = IMM_J;
            end
            OP_JALR: begin
                dec_regen = 1'b1;
                dec_pcjen = 1'b1;
                imm_sel   = IMM_I;
            end
            OP_BRANCH: begin
                dec_pcjen = 1'b1;
                dec_pcren = 1'b1;
                imm_sel   = IMM_B;
            end
            OP_LOAD: begin
                dec_regen = 1'b1;
                dec_memen = 1'b1;
                imm_sel   = IMM_I;
            end
            OP_STORE: begin
                dec_memen = 1'b1;
                imm_sel   = IMM_S;
            end
            OP_IMM: begin
                dec_regen = 1'b1;
                imm_sel   = IMM_I;
            end
            OP_REG: begin
                dec_regen = 1'b1;
            end
            OP_SYSTEM: begin
                dec_brken = (in_inst == 32'h0010_0073);
            end
            OP_IMM_32: begin
                if (XLEN == 64) begin
                    dec_regen = 1'b1;
                    imm_sel   = IMM_I;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OP_REG_32: begin
                if (XLEN == 64) begin
                    dec_regen = 1'b1;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
    end

    always_comb begin
        dec_imm = '0;
        case (imm_sel)
            IMM_I:   dec_imm = imm_i;
            IMM_S:   dec_imm = imm_s;
            IMM_B:   dec_imm = imm_b;
            IMM_U:   dec_imm = imm_u;
            IMM_J:   dec_imm = imm_j;
            default: dec_imm = '0;
        endcase
    end

    always_comb begin
        dec_rec         = '0;
        dec_rec.pc      = in_pc;
        dec_rec.opcode  = in_inst[6:0];
        dec_rec.func3   = in_inst[14:12];
        dec_rec.rs1     = in_inst[19:15];
        dec_rec.rs2     = in_inst[24:20];
        dec_rec.rd      = in_inst[11:7];
        dec_rec.imm     = dec_imm;
        dec_rec.regen   = dec_regen;
        dec_rec.pcjen   = dec_pcjen;
        dec_rec.pcren   = dec_pcren;
        dec_rec.brken   = dec_brken;
        dec_rec.memen   = dec_memen;
        dec_rec.illegal = dec_illegal;
    end

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign in_ready  = (count < FULL_CNT);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Entry storage carries no reset; only count/pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            entries[wr_ptr] <= dec_rec;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Data outputs are forced to zero whenever no record is presented.
    always_comb begin
        head = '0;
        if (out_valid) begin
            head = entries[rd_ptr];
        end
    end

    assign out_pc      = head.pc;
    assign out_opcode  = head.opcode;
    assign out_func3   = head.func3;
    assign out_rs1     = head.rs1;
    assign out_rs2     = head.rs2;
    assign out_rd      = head.rd;
    assign out_imm     = head.imm;
    assign out_regen   = head.regen;
    assign out_pcjen   = head.pcjen;
    assign out_pcren   = head.pcren;
    assign out_jalen   = head.regen & head.pcjen;
    assign out_brken   = head.brken;
    assign out_memen   = head.memen;
    assign out_illegal = head.illegal;

endmodule
